// File: rtl/scroll_boundary_buffer_pkg.sv
// Shared types and defaults for the scrolling river boundary buffer.
// Default geometry is 240 visible scanlines with two 10-bit banks per row.
package boundary_pkg;

    localparam int BB_WIDTH    = 10;
    localparam int BB_DEPTH    = 240;
    localparam int BB_CHANNELS = 2;
    localparam int ROW_W       = BB_CHANNELS * BB_WIDTH;

    typedef enum logic {INIT, RUN} bb_state_t;

    typedef logic [ROW_W-1:0] boundary_row_t;

    // Channel 0 (left bank) sits in the low bits, channel 1 (right bank) above it.
    localparam boundary_row_t BB_DEFAULT_VAL = {10'd600, 10'd40};

endpackage

// File: rtl/scroll_boundary_buffer_ram.sv
// DEPTH x DW row store: one write port and one registered read port.
// A read and a write to the same row in one cycle returns the old contents.
module boundary_ram
    import boundary_pkg::*;
#(
    parameter int DEPTH = BB_DEPTH,
    parameter int DW    = ROW_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is reset, so the array itself stays block-RAM friendly.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/scroll_boundary_buffer.sv
// Circular boundary store: the generator pushes rows at head, and the renderer reads
// relative to a head snapshot taken at frame start, so a frame never tears.
module scroll_boundary_buffer
    import boundary_pkg::*;
#(
    parameter int WIDTH    = BB_WIDTH,
    parameter int DEPTH    = BB_DEPTH,
    parameter int CHANNELS = BB_CHANNELS,
    parameter logic [CHANNELS*WIDTH-1:0] DEFAULT_VAL = BB_DEFAULT_VAL
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_valid,
    output logic                        push_ready,
    input  logic [CHANNELS*WIDTH-1:0]   push_data,
    input  logic                        frame_start,
    input  logic                        rd_en,
    input  logic [$clog2(DEPTH)-1:0]    rd_row,
    output logic                        rd_valid,
    output logic [CHANNELS*WIDTH-1:0]   rd_data,
    output logic                        init_done
);

    localparam int RW = CHANNELS * WIDTH;
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   EXT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   EXT_LAST = (AW+1)'(DEPTH - 1);

    bb_state_t     state, state_nxt;
    logic [AW-1:0] head, head_nxt;
    logic [AW-1:0] base_snap;
    logic [AW-1:0] init_ptr, init_ptr_nxt;
    logic          push_acc;

    logic          we;
    logic [AW-1:0] waddr;
    logic [RW-1:0] wdata;

    logic [AW:0]   base_w, row_w, phys;
    logic          row_oor;
    logic [AW-1:0] raddr;
    logic          use_def;
    logic [RW-1:0] ram_q;

    // Reset gates the accept so a push in the reset cycle can never land.
    assign push_acc = push_valid && (state == RUN) && !reset;
    assign head_nxt = !push_acc         ? head :
                      (head == PTR_LAST) ? '0   : head + PTR_ONE;

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        push_ready   = 1'b0;
        init_done    = 1'b0;
        we           = 1'b0;
        waddr        = init_ptr;
        wdata        = DEFAULT_VAL;
        case (state)
            INIT: begin
                we           = 1'b1;
                init_ptr_nxt = init_ptr + PTR_ONE;
                if (init_ptr == PTR_LAST) begin
                    state_nxt    = RUN;
                    init_ptr_nxt = '0;
                end
            end
            RUN: begin
                push_ready = 1'b1;
                init_done  = 1'b1;
                we         = push_acc;
                waddr      = head;
                wdata      = push_data;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            init_ptr  <= '0;
            head      <= '0;
            base_snap <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
            head     <= head_nxt;
            if (frame_start && state == RUN) base_snap <= head_nxt;
        end
    end

    // Row r of the snapshot is the r-th row behind base_snap; wrap by compare, not modulo.
    assign base_w  = {1'b0, base_snap};
    assign row_w   = {1'b0, rd_row};
    assign row_oor = row_w > EXT_LAST;
    assign phys    = (base_w > row_w) ? base_w - EXT_ONE - row_w
                                      : base_w + EXT_LAST - row_w;
    assign raddr   = row_oor ? '0 : AW'(phys);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            use_def  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) use_def <= (state == INIT) || row_oor;
        end
    end

    boundary_ram #(
        .DEPTH (DEPTH),
        .DW    (RW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we && !reset),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // use_def and ram_q only move together on rd_en, so rd_data holds between reads.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign rd_data[c*WIDTH +: WIDTH] = use_def ? DEFAULT_VAL[c*WIDTH +: WIDTH]
                                                   : ram_q[c*WIDTH +: WIDTH];
    end

endmodule

// File: tb/tb_scroll_boundary_buffer.sv
// Directed and random checks of scroll_boundary_buffer against a push-history model.
module tb_scroll_boundary_buffer;

    localparam int W  = 10;
    localparam int D  = 240;
    localparam int C  = 2;
    localparam int RW = C * W;
    localparam int AW = 8;
    localparam logic [RW-1:0] DEF = {10'd600, 10'd40};

    logic clk = 1'b0;
    logic reset, push_valid, frame_start, rd_en;
    logic push_ready, rd_valid, init_done;
    logic [RW-1:0] push_data, rd_data;
    logic [AW-1:0] rd_row;

    always #5 clk = ~clk;

    scroll_boundary_buffer #(
        .WIDTH(W), .DEPTH(D), .CHANNELS(C), .DEFAULT_VAL(DEF)
    ) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
        .push_data(push_data), .frame_start(frame_start), .rd_en(rd_en),
        .rd_row(rd_row), .rd_valid(rd_valid), .rd_data(rd_data), .init_done(init_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: every accepted row in push order; a snapshot is the count at frame start.
    logic [RW-1:0] hist[$];
    int            snap_cnt = 0;
    int            init_cnt = 0;
    bit            m_run    = 1'b0;
    bit            exp_vld  = 1'b0;
    logic [RW-1:0] exp_data = '0;

    function automatic logic [RW-1:0] model_row(int row);
        int idx;
        if (!m_run || row >= D) return DEF;
        idx = snap_cnt - 1 - row;
        // Later pushes that lap the buffer land in the same physical row.
        while (idx + D < hist.size()) idx += D;
        if (idx < 0) return DEF;
        return hist[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [RW-1:0] rexp;
        bit acc, fs;
        acc  = push_valid && m_run;
        fs   = frame_start && m_run;
        rexp = rd_en ? model_row(int'(rd_row)) : '0;
        @(posedge clk);
        #1;
        if (reset) begin
            hist.delete();
            snap_cnt = 0; init_cnt = 0; m_run = 1'b0;
            exp_vld  = 1'b0; exp_data = '0;
        end else begin
            if (acc) hist.push_back(push_data);
            if (fs) snap_cnt = hist.size();
            if (!m_run) begin
                init_cnt++;
                if (init_cnt == D) m_run = 1'b1;
            end
            exp_vld = rd_en;
            if (rd_en) exp_data = rexp;
        end
        chk("rd_valid",   32'(rd_valid),   32'(exp_vld));
        chk("rd_data",    32'(rd_data),    32'(exp_data));
        chk("init_done",  32'(init_done),  32'(m_run));
        chk("push_ready", 32'(push_ready), 32'(m_run));
    endtask

    task automatic push(input logic [RW-1:0] d);
        push_valid = 1'b1; push_data = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic rd(input int row, input logic [RW-1:0] want, input string tag);
        rd_en = 1'b1; rd_row = AW'(row);
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_data), 32'(want));
    endtask

    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        while (!init_done && cyc < 300) begin
            tick();
            cyc++;
        end
        chk(tag, 32'(cyc), 32'(D));
    endtask

    logic [RW-1:0] A, B, Cr, Dr, E, X;

    initial begin
        A  = {10'd100, 10'd500};
        B  = {10'd110, 10'd490};
        Cr = {10'd120, 10'd480};
        Dr = {10'd130, 10'd470};
        E  = {10'd140, 10'd460};
        X  = {10'd777, 10'd333};
        reset = 1'b1; push_valid = 1'b0; push_data = '0;
        frame_start = 1'b0; rd_en = 1'b0; rd_row = '0;
        tick(); tick();
        chk("reset_rd_data",   32'(rd_data),   32'd0);
        chk("reset_init_done", 32'(init_done), 32'd0);
        reset = 1'b0;

        // Init fill with a dropped push, ignored frame pulses and reads all offered.
        push_valid = 1'b1; push_data = A; rd_en = 1'b1; frame_start = 1'b1;
        wait_init("init_cycles");
        push_valid = 1'b0; rd_en = 1'b0; frame_start = 1'b0;
        rd(0,   DEF, "init_row0");
        rd(119, DEF, "init_row119");
        rd(239, DEF, "init_row239");

        push(A); push(B); push(Cr);
        frame();
        rd(0, Cr,  "order_row0");
        rd(1, B,   "order_row1");
        rd(2, A,   "order_row2");
        rd(3, DEF, "order_row3");

        push(Dr);
        rd(0, Cr, "tearfree_row0");
        frame();
        rd(0, Dr, "next_frame_row0");
        rd(1, Cr, "next_frame_row1");

        push_valid = 1'b1; push_data = E; frame_start = 1'b1;
        tick();
        push_valid = 1'b0; frame_start = 1'b0;
        rd(0, E,  "push_with_frame_row0");
        rd(1, Dr, "push_with_frame_row1");

        // Reset at init cycle 100 restarts the whole fill.
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (100) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        wait_init("reinit_cycles");
        rd(250, DEF, "oor_row250");
        rd(0,   DEF, "reinit_row0");

        for (int i = 0; i < 245; i++) push({10'(i), 10'(i)});
        frame();
        rd(0,   {10'd244, 10'd244}, "wrap_row0");
        rd(239, {10'd5, 10'd5},     "wrap_row239");
        rd(240, DEF,                "wrap_row240_oor");
        push(X);
        frame();
        rd(0,   X,                  "wrap2_row0");
        rd(239, {10'd6, 10'd6},     "wrap2_row239");

        for (int i = 0; i < 3000; i++) begin
            push_valid  = ($urandom_range(0, 3) != 0);
            push_data   = RW'($urandom);
            frame_start = ($urandom_range(0, 15) == 0);
            rd_en       = ($urandom_range(0, 1) != 0);
            rd_row      = AW'($urandom_range(0, 255));
            tick();
        end
        push_valid = 1'b0; frame_start = 1'b0; rd_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scroll_boundary_buffer.md
Name: scroll_boundary_buffer

Overview:
- Parametrised, tear-free store of per-scanline river boundary positions for the scrolling playfield.
- Terrain generator pushes one new row (all channels, e.g. left and right bank) per scroll step. The renderer reads rows by screen line.
- Uses a circular buffer with a head pointer instead of a shifting mega-register. Reads use a pointer snapshot taken at frame start, so a frame never tears mid-scan.
- Reset fills the buffer with default banks via an init state machine.

Parameters:
- WIDTH, 10, bits per boundary value (x position).
- DEPTH, 240, number of stored rows (visible scanlines).
- CHANNELS, 2, boundary values per row (channel 0 = left bank, 1 = right bank).
- DEFAULT_VAL, {10'd600, 10'd40}, per-channel init/out-of-range value, packed like push_data.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  new row offered.
- push_ready  out  1  buffer accepts push (high only in RUN).
- push_data  in  CHANNELS*WIDTH  new row; channel c at bits [c*WIDTH +: WIDTH].
- frame_start  in  1  one-cycle pulse at vsync; snapshots the read base.
- rd_en  in  1  read request.
- rd_row  in  $clog2(DEPTH)  screen row; 0 = newest row in the snapshot.
- rd_valid  out  1  rd_data valid (one cycle after rd_en).
- rd_data  out  CHANNELS*WIDTH  row contents.
- init_done  out  1  high once the init fill has completed.

Behaviour:
- Clock is clk. Reset is synchronous and active-high. Both are fixed.
- Reset values: push_ready=0, rd_valid=0, rd_data=0, init_done=0, head=0, base_snap=0, init_ptr=0, state=INIT.
- FSM states:
  - INIT: each cycle writes DEFAULT_VAL to mem[init_ptr] and increments init_ptr. After the write at DEPTH-1, go to RUN. This takes exactly DEPTH cycles after reset deasserts.
  - RUN: push_ready=1 and init_done=1. Stays in RUN until reset.
- Reset asserted in any state, including mid-INIT: returns to INIT with init_ptr=0 and restarts the full fill.
- Push: a push is accepted when push_valid && push_ready. It writes mem[head]=push_data, then head = (head==DEPTH-1) ? 0 : head+1. Pushes with push_ready=0 are dropped, with no side effects.
- Snapshot: on frame_start in RUN, base_snap takes head_next (the head value after any same-cycle push). A push coinciding with frame_start is therefore visible in that frame. frame_start during INIT is ignored.
- Read address: phys = (base_snap > rd_row) ? base_snap-1-rd_row : base_snap+DEPTH-1-rd_row. Width is $clog2(DEPTH)+1 internally, with no modulo operator.
- Read latency is exactly 1 cycle. Reads are registered: rd_valid(t+1)=rd_en(t), and rd_data holds its last value when rd_valid=0.
- rd_row >= DEPTH: rd_data = DEFAULT_VAL, rd_valid still asserts.
- rd_en during INIT: rd_data = DEFAULT_VAL, rd_valid asserts.
- Pushes after a snapshot do not change reads until the next frame_start. More than DEPTH pushes within one frame overwrite rows visible in the snapshot; this is an accepted hazard and is not flagged.
- Memory: single write port (the push or the init write, mutually exclusive by state) and one synchronous read port, so it maps to block RAM.
- Same-cycle read and push at the same physical row: read returns the old data (read-before-write).

Decomposition:
- Package boundary_pkg holds:
  - localparam ROW_W = CHANNELS*WIDTH.
  - typedef enum logic {INIT, RUN} bb_state_t.
  - typedef logic [ROW_W-1:0] boundary_row_t.
  - The default DEFAULT_VAL constant.
- One sub-module, boundary_ram: DEPTH x ROW_W, 1 write port, 1 synchronous read port, read-before-write.
- Pointer arithmetic and the FSM stay in the top module.

Test Plan:
- Init fill: deassert reset, then count cycles. init_done and push_ready rise exactly 240 cycles later. Reading rows 0, 119 and 239 then returns {600, 40}.
- Push and snapshot ordering: push rows A={100,500}, B={110,490}, C={120,480}, then pulse frame_start. Reads return row0=C, row1=B, row2=A, row3=default, each with rd_valid one cycle after rd_en.
- Tear-free: after the snapshot, push D={130,470}. Reading row 0 still returns C. After the next frame_start, row 0 = D and row 1 = C.
- Wrap-around: push 245 distinct rows (value = index), then pulse frame_start. Row 0 = 244, row 239 = 5, head = 5.
- Simultaneous events: push E together with frame_start, in the same cycle. Row 0 = E. A push with push_valid=1 during INIT is dropped: the buffer stays default and head stays 0.
- Reset mid-init and out-of-range read: assert reset at init cycle 100. The fill restarts and init_done follows 240 cycles after the release. rd_row=250 returns the default with rd_valid=1.
